prog_loader: RTL and testbench

- Hardware counterpart to preloading program RAM by file.
- Receives a byte stream over a valid/ready interface and packs it into DATA_WIDTH-bit words.
- Writes the words sequentially into the CPU's instruction/data RAM through a single write port.
- Holds the CPU in reset until the requested number of words is written, then releases it.
- Sits between an external byte source (UART receiver/debug port) and the RAM write port, alongside Cpu.

---
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Streams a program image into the CPU's instruction/data RAM. Bytes arrive
//   on a valid/ready interface. They are packed big-endian into DATA_WIDTH-bit
//   words and written to consecutive RAM addresses starting at 0. The CPU is
//   held in reset (cpu_rst=0) until the requested number of words is written.
//
//   Ports
//     clk, rst      : system clock (rising edge), async active-low reset
//     start         : one-cycle load request, honoured only in IDLE or DONE
//     word_count    : number of words to load, sampled with an accepted start
//     in_data/in_valid/in_ready : byte stream input
//     mem_we/mem_addr/mem_wdata : RAM write port
//     cpu_rst       : active-low CPU reset, released only in DONE
//     busy/done/error : load in progress / last load complete / last start rejected
module prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0]      BLAST = BCW'(BPW - 1);
    // Largest legal word count: the full RAM depth, 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] MAXW  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t              state, nstate;
    logic [BCW-1:0]      bcnt;
    logic [ADDR_WIDTH:0] wcnt;
    logic [ADDR_WIDTH:0] wtotal;
    logic                start_ok, cnt_zero, cnt_bad, accept, last_byte, last_word;

    // DONE behaves like IDLE for start, so a finished load can be restarted
    // directly without going through reset.
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign cnt_zero  = (word_count == '0);
    assign cnt_bad   = (word_count > MAXW);
    assign accept    = in_valid && (state == RECV);
    assign last_byte = (bcnt == BLAST);
    assign last_word = ((wcnt + ONE) == wtotal);

    // Status/handshake outputs are pure decodes of the state, so an async
    // reset drops them (including mem_we) immediately.
    assign in_ready = (state == RECV);
    assign busy     = (state == RECV) || (state == WRITE);
    assign mem_we   = (state == WRITE);
    assign cpu_rst  = (state == DONE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (cnt_bad)       nstate = IDLE;
                    else if (cnt_zero) nstate = DONE;
                    else               nstate = RECV;
                end
            end
            RECV:    if (accept && last_byte) nstate = WRITE;
            WRITE:   nstate = last_word ? DONE : RECV;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            bcnt      <= '0;
            wcnt      <= '0;
            wtotal    <= '0;
            error     <= 1'b0;
        end else begin
            if (start_ok) begin
                error <= cnt_bad;
                if (!cnt_bad) begin
                    wtotal   <= word_count;
                    mem_addr <= '0;
                    wcnt     <= '0;
                    bcnt     <= '0;
                end
            end
            if (accept) begin
                // Big-endian: earlier bytes shift toward the MSB.
                mem_wdata <= (mem_wdata << 8) | DATA_WIDTH'(in_data);
                bcnt      <= last_byte ? '0 : bcnt + 1'b1;
            end
            if (state == WRITE) begin
                wcnt <= wcnt + ONE;
                // The address stays put on the final word, so it never wraps.
                if (!last_word) mem_addr <= mem_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (DATA_WIDTH=32, ADDR_WIDTH=8).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  word_count = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_rst, busy, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write-port log: WRITE lasts one cycle, so one negedge per pulse.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] wc);
        start = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a byte and hold it (valid high) until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 64'(t), 64'(0));
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_mem_we"},   64'(mem_we),   64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_wdata"},    64'(mem_wdata), 64'(0));
        chk({tag, "_cpu_rst"},  64'(cpu_rst),  64'(0));
        chk({tag, "_busy"},     64'(busy),     64'(0));
        chk({tag, "_done"},     64'(done),     64'(0));
        chk({tag, "_error"},    64'(error),    64'(0));
    endtask

    initial begin
        int errs;
        logic [31:0] expw;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b1;
        @(negedge clk);

        // ---- basic 2-word load, valid continuously high ----
        wa.delete(); wd.delete();
        do_start(9'd2);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_ready", 64'(in_ready), 64'(1));
        chk("t1_cpu_rst", 64'(cpu_rst), 64'(0));
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        chk("t1_we0", 64'(mem_we), 64'(1));
        chk("t1_addr0", 64'(mem_addr), 64'(0));
        chk("t1_data0", 64'(mem_wdata), 64'h12345678);
        chk("t1_ready_wr", 64'(in_ready), 64'(0));
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        in_valid = 1'b0;
        chk("t1_we1", 64'(mem_we), 64'(1));
        chk("t1_addr1", 64'(mem_addr), 64'(1));
        chk("t1_data1", 64'(mem_wdata), 64'h9ABCDEF0);
        @(negedge clk);
        chk("t1_done", 64'(done), 64'(1));
        chk("t1_cpu_rst_rel", 64'(cpu_rst), 64'(1));
        chk("t1_busy_end", 64'(busy), 64'(0));
        chk("t1_nwr", 64'(wa.size()), 64'(2));

        // ---- restart from DONE, with a 3-cycle gap between bytes 2 and 3 ----
        wa.delete(); wd.delete();
        do_start(9'd2);
        chk("t2_cpu_rst", 64'(cpu_rst), 64'(0));
        chk("t2_done", 64'(done), 64'(0));
        chk("t2_busy", 64'(busy), 64'(1));
        send_byte(8'h12); send_byte(8'h34);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_gap_ready", 64'(in_ready), 64'(1));
        end
        send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_done_end", 64'(done), 64'(1));
        chk("t2_nwr", 64'(wa.size()), 64'(2));
        if (wa.size() == 2) begin
            chk("t2_a0", 64'(wa[0]), 64'(0));
            chk("t2_d0", 64'(wd[0]), 64'h12345678);
            chk("t2_a1", 64'(wa[1]), 64'(1));
            chk("t2_d1", 64'(wd[1]), 64'h9ABCDEF0);
        end

        // ---- out-of-range count: rejected, back to IDLE ----
        wa.delete(); wd.delete();
        do_start(9'd257);
        chk("t3_error", 64'(error), 64'(1));
        chk("t3_cpu_rst", 64'(cpu_rst), 64'(0));
        chk("t3_done", 64'(done), 64'(0));
        chk("t3_busy", 64'(busy), 64'(0));
        chk("t3_ready", 64'(in_ready), 64'(0));
        repeat (2) @(negedge clk);
        chk("t3_nwr", 64'(wa.size()), 64'(0));

        // ---- zero count from IDLE: straight to DONE ----
        do_start(9'd0);
        chk("t4_done", 64'(done), 64'(1));
        chk("t4_cpu_rst", 64'(cpu_rst), 64'(1));
        chk("t4_error", 64'(error), 64'(0));
        chk("t4_nwr", 64'(wa.size()), 64'(0));

        // ---- start during RECV is ignored ----
        wa.delete(); wd.delete();
        do_start(9'd1);
        send_byte(8'hCA); send_byte(8'hFE);
        in_valid = 1'b0;
        do_start(9'd3);
        chk("t5_busy", 64'(busy), 64'(1));
        chk("t5_ready", 64'(in_ready), 64'(1));
        send_byte(8'hBA); send_byte(8'hBE);
        in_valid = 1'b0;
        chk("t5_data", 64'(mem_wdata), 64'hCAFEBABE);
        @(negedge clk);
        chk("t5_done", 64'(done), 64'(1));
        chk("t5_nwr", 64'(wa.size()), 64'(1));

        // ---- async reset mid-load ----
        wa.delete(); wd.delete();
        do_start(9'd2);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_vals("t6_async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_nwr", 64'(wa.size()), 64'(1));
        wa.delete(); wd.delete();
        do_start(9'd1);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_done", 64'(done), 64'(1));
        chk("t6_nwr2", 64'(wa.size()), 64'(1));
        if (wa.size() == 1) begin
            chk("t6_addr", 64'(wa[0]), 64'(0));
            chk("t6_data", 64'(wd[0]), 64'hA1B2C3D4);
        end

        // ---- full-depth load: byte n carries n mod 256 ----
        wa.delete(); wd.delete();
        do_start(9'd256);
        chk("t7_error", 64'(error), 64'(0));
        for (int n = 0; n < 1024; n++) send_byte(8'(n));
        in_valid = 1'b0;
        @(negedge clk);
        chk("t7_done", 64'(done), 64'(1));
        chk("t7_cpu_rst", 64'(cpu_rst), 64'(1));
        chk("t7_nwr", 64'(wa.size()), 64'(256));
        errs = 0;
        for (int i = 0; i < wa.size(); i++) begin
            expw = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            if (wa[i] !== 8'(i) || wd[i] !== expw) errs++;
        end
        chk("t7_word_errs", 64'(errs), 64'(0));
        if (wa.size() > 0) chk("t7_last_addr", 64'(wa[wa.size()-1]), 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
